// File: rtl/mdu_div_seq.sv
// mdu_div_seq: iterative 32-bit radix-2 restoring divider for DIV/DIVU.
// It produces one quotient bit per cycle; the result is {remainder, quotient}.
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor completes in one
// cycle with a zero result instead of running the full iteration.
//
// state | meaning
// FREE  | idle, waiting for start_i (without annul_i)
// ON    | iterating, 32 cycles, counter 0..31
// END   | result valid, ready_o held until start_i drops
module mdu_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {FREE, ON, END} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        sgn_mode;
  logic        sign1;
  logic        sign2;
  logic [31:0] dvsr;
  logic [31:0] rem;
  logic [31:0] quo;

  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] rem_fix;
  logic [31:0] quo_fix;

  // Operand magnitudes. |INT_MIN| is 0x80000000, which fits as unsigned.
  always_comb begin
    mag1 = opdata1_i;
    mag2 = opdata2_i;
    if (signed_div_i && opdata1_i[31]) mag1 = ~opdata1_i + 32'd1;
    if (signed_div_i && opdata2_i[31]) mag2 = ~opdata2_i + 32'd1;
  end

  // One restoring step, plus the sign correction used on the last step.
  always_comb begin
    shifted = {rem, quo[31]};
    diff    = shifted - {1'b0, dvsr};
    if (!diff[32]) begin
      rem_nxt = diff[31:0];
      quo_nxt = {quo[30:0], 1'b1};
    end else begin
      // Restoring branch: shifted < dvsr, so its top bit is zero.
      rem_nxt = shifted[31:0];
      quo_nxt = {quo[30:0], 1'b0};
    end
    quo_fix = quo_nxt;
    rem_fix = rem_nxt;
    if (sgn_mode && (sign1 != sign2)) quo_fix = ~quo_nxt + 32'd1;
    if (sgn_mode && sign1)            rem_fix = ~rem_nxt + 32'd1;
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= 5'd0;
      sgn_mode <= 1'b0;
      sign1    <= 1'b0;
      sign2    <= 1'b0;
      dvsr     <= 32'd0;
      rem      <= 32'd0;
      quo      <= 32'd0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= 64'd0;
          if (start_i && !annul_i) begin
`ifdef DIV_ZERO_FAST_EN
            if (opdata2_i == 32'd0) begin
              state   <= END;
              ready_o <= 1'b1;
            end else begin
              state <= ON;
            end
`else
            state <= ON;
`endif
            sgn_mode <= signed_div_i;
            sign1    <= signed_div_i & opdata1_i[31];
            sign2    <= signed_div_i & opdata2_i[31];
            dvsr     <= mag2;
            quo      <= mag1;
            rem      <= 32'd0;
            cnt      <= 5'd0;
          end
        end
        ON: begin
          if (annul_i) begin
            state    <= FREE;
            ready_o  <= 1'b0;
            result_o <= 64'd0;
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state    <= END;
              ready_o  <= 1'b1;
              result_o <= {rem_fix, quo_fix};
            end
          end
        end
        END: begin
          if (!start_i) begin
            state    <= FREE;
            ready_o  <= 1'b0;
            result_o <= 64'd0;
          end
        end
        default: begin
          state    <= FREE;
          ready_o  <= 1'b0;
          result_o <= 64'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_div_seq.sv
// tb_mdu_div_seq: directed and random checks of mdu_div_seq against an
// arithmetic reference model.
module tb_mdu_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int total = 0;
  int bad   = 0;

  mdu_div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    ma = (sgn && a[31]) ? 32'(-a) : a;
    mb = (sgn && b[31]) ? 32'(-b) : b;
`ifdef DIV_ZERO_FAST_EN
    if (b == 32'd0) return 64'd0;
`endif
    if (mb == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = ma;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (sgn && (a[31] != b[31])) q = 32'(-q);
    if (sgn && a[31])            r = 32'(-r);
    return {r, q};
  endfunction

  function automatic int ref_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    if (b == 32'd0) return 1;
`endif
    return 33;
  endfunction

  // Wait for ready_o, scrambling operands to prove they are not re-sampled.
  task automatic wait_ready(input int maxc, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
      opdata1_i = $urandom;
      opdata2_i = $urandom;
    end while (!ready_o && lat < maxc);
  endtask

  // Full transaction from cycle 0; leaves start_i dropped and the DUT in FREE.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [63:0] exp_res;
    int lat;
    exp_res      = ref_div(sgn, a, b);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    wait_ready(40, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(ref_lat(b)));
    chk({tag, "_res"}, result_o, exp_res);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
      chk({tag, "_hold_res"}, result_o, exp_res);
    end
    start_i = 1'b0;
    tick();
    chk({tag, "_drop_rdy"}, 64'(ready_o), 64'd0);
    chk({tag, "_drop_res"}, result_o, 64'd0);
  endtask

  initial begin
    int lat;
    logic seen;
    logic sgn;
    logic [31:0] a, b;

    rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    start_i = 1'b0; annul_i = 1'b0;
    tick(); tick();
    chk("reset_rdy", 64'(ready_o), 64'd0);
    chk("reset_res", result_o, 64'd0);
    rst = 1'b0;

    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 0);
    chk("const_100_7", ref_div(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    do_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    do_div("divu_5_0", 1'b0, 32'd5, 32'd0, 0);
    do_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 0);
    do_div("held5", 1'b0, 32'd1000, 32'd33, 5);

    // Annul at cycle 10, then an immediate new DIVU 9/3.
    signed_div_i = 1'b0; opdata1_i = 32'd12345; opdata2_i = 32'd17; start_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen |= ready_o;
    end
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    chk("annul_rdy_never", 64'(seen | ready_o), 64'd0);
    chk("annul_res", result_o, 64'd0);
    opdata1_i = 32'd9; opdata2_i = 32'd3;
    wait_ready(40, lat);
    chk("after_annul_lat", 64'(lat), 64'd33);
    chk("after_annul_res", result_o, 64'h00000000_00000003);
    // annul_i is ignored in END.
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    chk("end_annul_rdy", 64'(ready_o), 64'd1);
    chk("end_annul_res", result_o, 64'h00000000_00000003);
    start_i = 1'b0;
    tick();
    chk("after_annul_drop", 64'(ready_o), 64'd0);

    // start_i and annul_i together in FREE: no start.
    opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1; annul_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen |= ready_o;
    end
    chk("free_annul_nostart", 64'(seen), 64'd0);
    annul_i = 1'b0;
    opdata1_i = 32'd50; opdata2_i = 32'd5;
    wait_ready(40, lat);
    chk("free_annul_then_lat", 64'(lat), 64'd33);
    chk("free_annul_then_res", result_o, 64'h00000000_0000000A);
    start_i = 1'b0;
    tick();

    // Reset at cycle 20 of a division.
    opdata1_i = 32'd777; opdata2_i = 32'd3; start_i = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    start_i = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_mid_rdy", 64'(ready_o), 64'd0);
    chk("rst_mid_res", result_o, 64'd0);
    do_div("after_rst", 1'b1, 32'hFFFF_FC00, 32'd10, 1);

    // Random operands, biased toward edge values.
    for (int n = 0; n < 12; n++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'd1;
        3: b = b >> $urandom_range(8, 31);
        default: ;
      endcase
      if (n == 0) a = 32'h8000_0000;
      do_div($sformatf("rand%0d", n), sgn, a, b, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
